// File: rtl/uart_pkg.sv
// Shared types and defaults for the configurable UART receiver.
// Holds the FSM state enum and the data-length legalisation helper.
package uart_pkg;

    localparam int OS_RATE_DEF       = 16;
    localparam int MAX_DATA_BITS_DEF = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_cfg_state_e;

    // Lengths outside the supported range fall back to 8 data bits.
    function automatic logic [3:0] eff_data_bits(input logic [3:0] cfg, input int max_bits);
        if (int'(cfg) >= 5 && int'(cfg) <= max_bits) begin
            return cfg;
        end
        return 4'd8;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchronizer for the serial line plus a 3-sample majority voter.
// The vote combines the two stored samples with the current synchronized value.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    input  logic sample_i,
    output logic rx_s_o,
    output logic vote_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 2'b11;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            if (sample_i) begin
                hist_q <= {hist_q[0], sync2_q};
            end
        end
    end

    assign rx_s_o = sync2_q;
    assign vote_o = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with run-time data length, parity and stop-bit count.
// Detects parity errors, framing errors and line breaks; results are held until the next frame.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OS_RATE       = OS_RATE_DEF,
    parameter int MAX_DATA_BITS = MAX_DATA_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bclk,
    input  logic                     rx,
    input  logic [3:0]               cfg_data_bits,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_parity_odd,
    input  logic                     cfg_stop2,
    output logic [MAX_DATA_BITS-1:0] dout,
    output logic                     rx_done,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     break_det,
    output logic                     busy
);

    localparam int CW = $clog2(OS_RATE);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t MID_LO = cnt_t'(OS_RATE / 2 - 1);
    localparam cnt_t MID    = cnt_t'(OS_RATE / 2);
    localparam cnt_t MID_HI = cnt_t'(OS_RATE / 2 + 1);
    localparam cnt_t LAST   = cnt_t'(OS_RATE - 1);

    rx_cfg_state_e            state_q, state_d;
    cnt_t                     cnt_q, cnt_d;
    logic [3:0]               bit_q, bit_d;
    logic [3:0]               len_q, len_d;
    logic                     par_en_q, par_en_d;
    logic                     par_odd_q, par_odd_d;
    logic                     stop2_q, stop2_d;
    logic                     stop_idx_q, stop_idx_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                     all_zero_q, all_zero_d;
    logic                     perr_q, perr_d;
    logic                     stop_err_q, stop_err_d;
    logic [MAX_DATA_BITS-1:0] dout_q, dout_d;
    logic                     done_q, done_d;
    logic                     parity_err_q, parity_err_d;
    logic                     frame_err_q, frame_err_d;
    logic                     break_det_q, break_det_d;

    logic rx_s;
    logic vote;
    logic sample;
    logic decide;
    logic wrap;

    assign sample = bclk && (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
                    && (cnt_q == MID_LO || cnt_q == MID || cnt_q == MID_HI);
    assign decide = bclk && (cnt_q == MID_HI);
    assign wrap   = bclk && (cnt_q == LAST);

    uart_rx_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
        .rx_i     (rx),
        .sample_i (sample),
        .rx_s_o   (rx_s),
        .vote_o   (vote)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            len_q        <= 4'd8;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            stop2_q      <= 1'b0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            all_zero_q   <= 1'b0;
            perr_q       <= 1'b0;
            stop_err_q   <= 1'b0;
            dout_q       <= '0;
            done_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            len_q        <= len_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            stop2_q      <= stop2_d;
            stop_idx_q   <= stop_idx_d;
            shift_q      <= shift_d;
            all_zero_q   <= all_zero_d;
            perr_q       <= perr_d;
            stop_err_q   <= stop_err_d;
            dout_q       <= dout_d;
            done_q       <= done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
        end
    end

    // Each bit is decided at MID_HI; the FSM moves on at the bit boundary,
    // except for the last stop bit, which completes the frame at its decision point.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        len_d        = len_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        stop2_d      = stop2_q;
        stop_idx_d   = stop_idx_q;
        shift_d      = shift_q;
        all_zero_d   = all_zero_q;
        perr_d       = perr_q;
        stop_err_d   = stop_err_q;
        dout_d       = dout_q;
        done_d       = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;

        if (state_q != ST_IDLE && bclk) begin
            cnt_d = wrap ? '0 : cnt_q + cnt_t'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    cnt_d      = '0;
                    bit_d      = '0;
                    len_d      = eff_data_bits(cfg_data_bits, MAX_DATA_BITS);
                    par_en_d   = cfg_parity_en;
                    par_odd_d  = cfg_parity_odd;
                    stop2_d    = cfg_stop2;
                    stop_idx_d = 1'b0;
                    shift_d    = '0;
                    all_zero_d = 1'b1;
                    perr_d     = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (decide && vote) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d[bit_q] = vote;
                    if (vote) begin
                        all_zero_d = 1'b0;
                    end
                end
                if (wrap) begin
                    if (bit_q == len_q - 4'd1) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    perr_d = ((^shift_q) ^ vote) != par_odd_q;
                    if (vote) begin
                        all_zero_d = 1'b0;
                    end
                end
                if (wrap) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (!stop_idx_q && all_zero_q && !vote) begin
                        state_d      = ST_BREAK;
                        done_d       = 1'b1;
                        dout_d       = shift_q;
                        parity_err_d = perr_q;
                        frame_err_d  = 1'b1;
                        break_det_d  = 1'b1;
                    end else if (stop2_q && !stop_idx_q) begin
                        stop_err_d = !vote;
                    end else begin
                        state_d      = ST_IDLE;
                        done_d       = 1'b1;
                        dout_d       = shift_q;
                        parity_err_d = perr_q;
                        frame_err_d  = stop_err_q | !vote;
                        break_det_d  = 1'b0;
                    end
                end
                if (wrap) begin
                    stop_idx_d = 1'b1;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dout       = dout_q;
    assign rx_done    = done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed frames plus random configurations,
// checked every cycle against a frame-level model of the expected results.
module tb_uart_rx_cfg;

    localparam int OS   = 16;
    localparam int MID  = OS / 2;
    localparam int MAXB = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            bclk = 1'b0;
    logic            rx = 1'b1;
    logic [3:0]      cfg_data_bits = 4'd8;
    logic            cfg_parity_en = 1'b0;
    logic            cfg_parity_odd = 1'b0;
    logic            cfg_stop2 = 1'b0;
    logic [MAXB-1:0] dout;
    logic            rx_done;
    logic            parity_err;
    logic            frame_err;
    logic            break_det;
    logic            busy;

    uart_rx_cfg #(.OS_RATE(OS), .MAX_DATA_BITS(MAXB)) dut (
        .clk            (clk),
        .rst            (rst),
        .bclk           (bclk),
        .rx             (rx),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .dout           (dout),
        .rx_done        (rx_done),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .break_det      (break_det),
        .busy           (busy)
    );

    typedef struct packed {
        logic [8:0] dout;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    exp_t expQ[$];
    exp_t heldExp = '0;
    int   compared = 0;
    int   mismatched = 0;
    int   doneCount = 0;
    int   tickNow = 0;
    int   lastDoneTick = 0;
    int   startTick = 0;
    int   divCnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        bclk = (divCnt == 3);
        divCnt = (divCnt + 1) % 4;
    end

    always @(posedge clk) begin
        if (bclk) tickNow++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Frame-level model: what a receiver must report for a given line pattern.
    function automatic exp_t modelFrame(input logic [3:0] cfgBits, input logic pen, input logic podd,
                                        input logic s2, input logic [8:0] data, input logic pbit,
                                        input logic st1, input logic st2);
        exp_t e;
        int   len;
        logic [8:0] d;
        logic brk;
        len = (cfgBits >= 4'd5 && int'(cfgBits) <= MAXB) ? int'(cfgBits) : 8;
        d = 9'(int'(data) & ((1 << len) - 1));
        e.dout = d;
        e.pe = pen ? ((($countones(d) % 2 == 1) ^ pbit) != podd) : 1'b0;
        brk = (d == 9'd0) && (!pen || !pbit) && !st1;
        e.bd = brk;
        e.fe = brk || !st1 || (s2 && !st2);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            heldExp = '0;
        end else begin
            if (rx_done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_rx_done", 32'(rx_done), 32'd0);
                end else begin
                    heldExp = expQ.pop_front();
                    doneCount++;
                    lastDoneTick = tickNow;
                end
            end
            checkOutput("dout", 32'(dout), 32'(heldExp.dout));
            checkOutput("parity_err", 32'(parity_err), 32'(heldExp.pe));
            checkOutput("frame_err", 32'(frame_err), 32'(heldExp.fe));
            checkOutput("break_det", 32'(break_det), 32'(heldExp.bd));
        end
    end

    task automatic waitTicks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!bclk) @(posedge clk);
        end
    endtask

    task automatic driveBit(input logic v, input int n);
        #1 rx = v;
        waitTicks(n);
    endtask

    // Sends one frame, queues the model's expectation, and scrambles cfg once the frame has started.
    task automatic applyStimulus(input logic [8:0] data, input logic [3:0] nb, input logic pen,
                                 input logic podd, input logic s2, input logic flipPar,
                                 input logic st1, input logic st2);
        logic bits[$];
        int   len;
        logic pbit;
        len = (nb >= 4'd5 && int'(nb) <= MAXB) ? int'(nb) : 8;
        pbit = ($countones(9'(int'(data) & ((1 << len) - 1))) % 2 == 1) ^ podd ^ flipPar;
        cfg_data_bits = nb;
        cfg_parity_en = pen;
        cfg_parity_odd = podd;
        cfg_stop2 = s2;
        expQ.push_back(modelFrame(nb, pen, podd, s2, data, pbit, st1, st2));
        for (int i = 0; i < len; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(st1);
        if (s2) bits.push_back(st2);
        waitTicks(1);
        #1 rx = 1'b0;
        startTick = tickNow;
        waitTicks(OS);
        cfg_data_bits = 4'($urandom);
        cfg_parity_en = 1'($urandom);
        cfg_parity_odd = 1'($urandom);
        cfg_stop2 = 1'($urandom);
        for (int i = 0; i < bits.size(); i++) begin
            if (i == bits.size() - 1 && !bits[i]) begin
                driveBit(1'b0, MID + 3);
                driveBit(1'b1, OS - MID - 3);
            end else begin
                driveBit(bits[i], OS);
            end
        end
        driveBit(1'b1, 2 * OS);
    endtask

    task automatic waitDone(input int target, input int bound);
        int t0;
        t0 = tickNow;
        while (doneCount < target && tickNow - t0 < bound) @(posedge clk);
        checkOutput("rx_done_count", 32'(doneCount), 32'(target));
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          base;
        int          t0;
        logic [8:0]  rd;
        logic [3:0]  rnb;

        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_rx_done", 32'(rx_done), 32'd0);
        checkOutput("reset_flags", 32'({parity_err, frame_err, break_det}), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        driveBit(1'b1, 8);

        $display("[TB] 8N1 0xA5");
        base = doneCount;
        applyStimulus(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        waitDone(base + 1, 64);
        checkOutput("a5_latency_ticks", 32'(lastDoneTick - startTick), 32'd154);
        checkOutput("a5_dout", 32'(dout), 32'h0A5);
        checkOutput("a5_flags", 32'({parity_err, frame_err, break_det}), 32'd0);

        $display("[TB] 7E1 0x35 bad parity");
        base = doneCount;
        applyStimulus(9'h035, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        waitDone(base + 1, 64);
        checkOutput("p35_dout", 32'(dout), 32'h035);
        checkOutput("p35_parity_err", 32'(parity_err), 32'd1);
        checkOutput("p35_frame_err", 32'(frame_err), 32'd0);

        $display("[TB] 8N2 0x3C second stop low");
        base = doneCount;
        applyStimulus(9'h03C, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        waitDone(base + 1, 64);
        checkOutput("s3c_dout", 32'(dout), 32'h03C);
        checkOutput("s3c_frame_err", 32'(frame_err), 32'd1);

        $display("[TB] start glitch");
        base = doneCount;
        waitTicks(1);
        #1 rx = 1'b0;
        t0 = tickNow;
        waitTicks(2);
        #2 checkOutput("glitch_busy_high", 32'(busy), 32'd1);
        waitTicks(2);
        #1 rx = 1'b1;
        waitTicks(t0 + 15 - tickNow);
        #2 checkOutput("glitch_busy_low", 32'(busy), 32'd0);
        driveBit(1'b1, 2 * OS);
        checkOutput("glitch_no_done", 32'(doneCount), 32'(base));

        $display("[TB] break");
        base = doneCount;
        cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_stop2 = 1'b0;
        expQ.push_back(modelFrame(4'd8, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0));
        waitTicks(1);
        #1 rx = 1'b0;
        waitTicks(12 * OS);
        #2 checkOutput("break_busy_high", 32'(busy), 32'd1);
        checkOutput("break_done_count", 32'(doneCount), 32'(base + 1));
        checkOutput("break_dout", 32'(dout), 32'd0);
        checkOutput("break_flags", 32'({frame_err, break_det}), 32'b11);
        rx = 1'b1;
        waitTicks(4);
        #2 checkOutput("break_busy_low", 32'(busy), 32'd0);
        driveBit(1'b1, OS);
        base = doneCount;
        applyStimulus(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        waitDone(base + 1, 64);
        checkOutput("after_break_dout", 32'(dout), 32'h055);

        $display("[TB] reset mid-frame");
        base = doneCount;
        cfg_data_bits = 4'd8;
        waitTicks(1);
        #1 rx = 1'b0;
        waitTicks(OS);
        driveBit(1'b1, OS);
        driveBit(1'b0, OS);
        driveBit(1'b0, OS);
        driveBit(1'b0, OS / 2);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_dout", 32'(dout), 32'd0);
        checkOutput("rst_rx_done", 32'(rx_done), 32'd0);
        checkOutput("rst_flags", 32'({parity_err, frame_err, break_det}), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        driveBit(1'b1, 2 * OS);
        checkOutput("rst_no_done", 32'(doneCount), 32'(base));
        applyStimulus(9'h081, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        waitDone(base + 1, 64);
        checkOutput("after_rst_dout", 32'(dout), 32'h081);

        $display("[TB] random frames");
        for (int i = 0; i < 30; i++) begin
            rd = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
            rnb = 4'($urandom);
            base = doneCount;
            applyStimulus(rd, rnb, 1'($urandom), 1'($urandom), 1'($urandom),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0,
                          $urandom_range(0, 5) != 0);
            waitDone(base + 1, 64);
        end

        driveBit(1'b1, OS);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
